// File: rtl/scalar_wb_scoreboard.sv
// Scalar writeback scoreboard: tracks outstanding scalar-register writes per
// register, stalls issue on RAW/WAW/capacity hazards, accumulates sticky
// FP/VALU error flags from commits and drains in-flight writes on a fence.
module scalar_wb_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int MAX_OUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic       issue_rd_we,
  input  logic [4:0] issue_rd,
  input  logic [4:0] issue_rs1,
  input  logic [4:0] issue_rs2,
  output logic       issue_stall,
  input  logic       s_we,
  input  logic [4:0] s_waddr,
  input  logic       wb_from_fp,
  input  logic       wb_from_valu,
  input  logic       wb_err_overflow,
  input  logic       wb_err_invalid,
  input  logic       csr_flags_clr,
  output logic [1:0] fp_flags,
  output logic [1:0] valu_flags,
  output logic       sb_err,
  input  logic       fence_req,
  output logic       fence_ack,
  output logic       busy
);

  localparam int TOT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, DRAIN, ACK} state_t;

  state_t           state_q;
  logic             fence_ack_q;
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [TOT_W-1:0] total_q, total_d;
  logic [1:0]       fp_flags_q, fp_flags_d;
  logic [1:0]       valu_flags_q, valu_flags_d;
  logic             sb_err_q, sb_err_d;
  logic             busy_q, busy_d;
  logic             raw_rs1, raw_rs2, waw_full, cap_full;
  logic             inc, dec, dec_ok, err_set;

  // Hazard detection from registered counts only; a same-cycle commit does not unblock
  always_comb begin
    raw_rs1     = (issue_rs1 != 5'd0) && (cnt_q[issue_rs1] != '0);
    raw_rs2     = (issue_rs2 != 5'd0) && (cnt_q[issue_rs2] != '0);
    waw_full    = issue_rd_we && (cnt_q[issue_rd] == CNT_MAX);
    cap_full    = issue_rd_we && (total_q == TOT_W'(MAX_OUT));
    issue_stall = issue_valid &&
                  ((state_q != IDLE) || raw_rs1 || raw_rs2 || waw_full || cap_full);
  end

  // Per-register counter and total update; x0 is never tracked and an
  // underflowing retire is held at zero and flagged instead of counted
  always_comb begin
    inc     = issue_valid && !issue_stall && issue_rd_we && (issue_rd != 5'd0);
    dec     = s_we && (s_waddr != 5'd0);
    dec_ok  = dec && (cnt_q[s_waddr] != '0);
    err_set = dec && (cnt_q[s_waddr] == '0);
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc && (issue_rd == 5'(i)) && !(dec_ok && (s_waddr == 5'(i))))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec_ok && (s_waddr == 5'(i)) && !(inc && (issue_rd == 5'(i))))
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
    total_d = total_q + TOT_W'(inc) - TOT_W'(dec_ok);
    busy_d  = (total_d != '0);
  end

  // Sticky flag accumulation; a same-cycle set beats the CSR clear
  always_comb begin
    fp_flags_d   = csr_flags_clr ? 2'b00 : fp_flags_q;
    valu_flags_d = csr_flags_clr ? 2'b00 : valu_flags_q;
    if (s_we && wb_from_fp)
      fp_flags_d = fp_flags_d | {wb_err_invalid, wb_err_overflow};
    if (s_we && wb_from_valu)
      valu_flags_d = valu_flags_d | {wb_err_invalid, wb_err_overflow};
    sb_err_d = sb_err_q | err_set;
  end

  // Scoreboard state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      total_q      <= '0;
      fp_flags_q   <= 2'b00;
      valu_flags_q <= 2'b00;
      sb_err_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
      total_q      <= total_d;
      fp_flags_q   <= fp_flags_d;
      valu_flags_q <= valu_flags_d;
      sb_err_q     <= sb_err_d;
      busy_q       <= busy_d;
    end
  end

  // Fence FSM: wait for all outstanding writes to retire, then pulse the ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fence_ack_q <= 1'b0;
    end else begin
      fence_ack_q <= 1'b0;
      case (state_q)
        IDLE:    if (fence_req) state_q <= DRAIN;
        DRAIN: begin
          if (total_q == '0) begin
            state_q     <= ACK;
            fence_ack_q <= 1'b1;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fp_flags   = fp_flags_q;
  assign valu_flags = valu_flags_q;
  assign sb_err     = sb_err_q;
  assign fence_ack  = fence_ack_q;
  assign busy       = busy_q;

endmodule
